// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - sequential instruction fetch with a PC-tagged FIFO and redirect flush
// Slots are reserved at request time so a returning word always finds room in the FIFO.
module instr_fetch_queue #(
   parameter int                DEPTH    = 4,
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic              instr_valid_o,
   input  logic              instr_ready_i,
   output logic [DATA_W-1:0] instr_o,
   output logic [ADDR_W-1:0] instr_pc_o
);
   localparam int                PW         = $clog2(DEPTH);
   localparam int                CW         = PW + 1;
   localparam logic [CW:0]       DEPTH_C    = (CW+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] WORD_C     = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [CW-1:0]     outst_q, outst_d;
   logic [CW-1:0]     drop_q, drop_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic              boot_q;
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [ADDR_W-1:0] pc_q   [DEPTH];

   logic              grant;
   logic              push;
   logic              pop;
   logic              rv_live;
   logic [CW:0]       inflight;

   assign inflight      = {1'b0, cnt_q} + {1'b0, outst_q};
   assign mem_req_o     = !rst_i && !boot_q && !redirect_i && (inflight < DEPTH_C);
   assign mem_addr_o    = fetch_pc_q;
   assign grant         = mem_req_o && mem_gnt_i;

   assign instr_valid_o = !rst_i && (cnt_q != '0);
   assign instr_o       = instr_valid_o ? data_q[rd_ptr_q] : '0;
   assign instr_pc_o    = instr_valid_o ? pc_q[rd_ptr_q]   : '0;

   // A response with nothing pending or being dropped is a protocol error and is ignored.
   assign rv_live       = mem_rvalid_i && ((drop_q != '0) || (outst_q != '0));
   assign push          = mem_rvalid_i && !redirect_i && (drop_q == '0) && (outst_q != '0);
   assign pop           = instr_valid_o && instr_ready_i && !redirect_i;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      cnt_d      = cnt_q;
      outst_d    = outst_q;
      drop_d     = drop_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      if (redirect_i) begin
         fetch_pc_d = redirect_pc_i & ALIGN_MASK;
         resp_pc_d  = redirect_pc_i & ALIGN_MASK;
         cnt_d      = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         outst_d    = '0;
         drop_d     = drop_q + outst_q - CW'(rv_live);
      end else begin
         if (grant)
            fetch_pc_d = fetch_pc_q + WORD_C;
         if (mem_rvalid_i && (drop_q != '0))
            drop_d = drop_q - CW'(1);
         if (push) begin
            resp_pc_d = resp_pc_q + WORD_C;
            wr_ptr_d  = wr_ptr_q + PW'(1);
         end
         if (pop)
            rd_ptr_d = rd_ptr_q + PW'(1);
         cnt_d   = cnt_q + CW'(push) - CW'(pop);
         outst_d = outst_q + CW'(grant) - CW'(push);
      end
   end

   always_ff @(posedge clk_i) begin
      boot_q <= rst_i;
      if (rst_i) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         cnt_q      <= '0;
         outst_q    <= '0;
         drop_q     <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         cnt_q      <= cnt_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push && !rst_i) begin
         data_q[wr_ptr_q] <= mem_rdata_i;
         pc_q[wr_ptr_q]   <= resp_pc_q;
      end
   end
endmodule
